// File: rtl/vector_chunk_streamer.sv
// vector_chunk_streamer: streams buffered row/vector chunks to a dot-product consumer and returns its result.
// Optional macro STREAMER_TIMEOUT_EN adds a 1024-cycle watchdog on the consumer's finish.
module vector_chunk_streamer #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int max_chunks    = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic                                 wr_sel,
    input  logic [$clog2(max_chunks)-1:0]        wr_addr,
    input  logic [element_width*no_of_units-1:0] wr_data,
    input  logic                                 start,
    input  logic [31:0]                          total,
    output logic [element_width*no_of_units-1:0] first_row_plus_additional,
    output logic [element_width*no_of_units-1:0] vector2,
    output logic                                 outsider_read_now,
    input  logic                                 I_am_ready,
    input  logic                                 finish,
    input  logic [element_width-1:0]             dot_product_output,
    output logic [element_width-1:0]             result,
    output logic                                 result_valid,
    output logic                                 busy,
    output logic                                 err
);
    localparam int CW  = element_width * no_of_units;
    localparam int AW  = $clog2(max_chunks);
    localparam int KW  = $clog2(max_chunks + 3);
    localparam int CAP = max_chunks * no_of_units;

    typedef enum logic [2:0] {IDLE, WAIT_READY, STREAM, WAIT_FINISH, DONE} state_t;

    state_t                     r_state, w_next;
    logic [CW-1:0]              r_row_buf [max_chunks];
    logic [CW-1:0]              r_vec_buf [max_chunks];
    logic [CW-1:0]              r_row_out, r_vec_out, w_row_beat, w_vec_beat;
    logic [KW-1:0]              r_k, w_k_next, r_last;
    logic [AW-1:0]              w_addr;
    logic [31:0]                r_total;
    logic [element_width-1:0]   r_result;
    logic                       r_err, r_valid, w_total_ok, w_start_ok, w_k_in, w_timeout;

    assign w_total_ok = total != 32'd0 && total <= 32'(CAP);
    assign w_start_ok = r_state == IDLE && start && w_total_ok;

`ifdef STREAMER_TIMEOUT_EN
    logic [15:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset || r_state != WAIT_FINISH)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end
    assign w_timeout = r_state == WAIT_FINISH && r_cnt == 16'd1023;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_k_next = r_k;
        case (r_state)
            IDLE:        w_next = w_start_ok ? WAIT_READY : IDLE;
            WAIT_READY:  w_next = I_am_ready ? STREAM : WAIT_READY;
            STREAM: begin
                if (I_am_ready) begin
                    w_next   = r_k == r_last ? WAIT_FINISH : STREAM;
                    w_k_next = r_k == r_last ? '0 : r_k + 1'b1;
                end
            end
            WAIT_FINISH: w_next = (finish || w_timeout) ? DONE : WAIT_FINISH;
            DONE:        w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    // Beat data is built for the index that will be current next cycle, so the
    // registered outputs line up with outsider_read_now.
    assign w_k_in = w_k_next < KW'(max_chunks);
    assign w_addr = AW'(w_k_next);
    always_comb begin
        w_row_beat = '0;
        w_vec_beat = '0;
        for (int j = 0; j < no_of_units; j++) begin
            w_row_beat[j*element_width +: element_width] =
                (w_k_in && 32'(w_k_next) * 32'(no_of_units) + 32'(j) < r_total)
                ? r_row_buf[w_addr][j*element_width +: element_width] : '0;
            w_vec_beat[j*element_width +: element_width] =
                (w_k_in && 32'(w_k_next) * 32'(no_of_units) + 32'(j) < r_total)
                ? r_vec_buf[w_addr][j*element_width +: element_width] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && r_state == IDLE) begin
            if (wr_sel)
                r_vec_buf[wr_addr] <= wr_data;
            else
                r_row_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_last    <= '0;
            r_total   <= '0;
            r_err     <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_row_out <= '0;
            r_vec_out <= '0;
        end else begin
            r_state   <= w_next;
            r_k       <= w_k_next;
            r_err     <= (r_state == IDLE && start && !w_total_ok) || (w_timeout && !finish);
            r_valid   <= r_state == WAIT_FINISH && finish;
            r_row_out <= w_next == STREAM ? w_row_beat : '0;
            r_vec_out <= w_next == STREAM ? w_vec_beat : '0;
            if (r_state == WAIT_FINISH && finish)
                r_result <= dot_product_output;
            if (w_start_ok) begin
                r_total <= total;
                r_last  <= KW'(total / 32'(no_of_units) + 32'd1);
            end
        end
    end

    assign first_row_plus_additional = r_row_out;
    assign vector2                   = r_vec_out;
    assign outsider_read_now         = r_state == STREAM && I_am_ready;
    assign result                    = r_result;
    assign result_valid              = r_valid;
    assign busy                      = r_state != IDLE;
    assign err                       = r_err;
endmodule

// File: tb/tb_vector_chunk_streamer.sv
// tb_vector_chunk_streamer: directed bench with a beat-queue model for vector_chunk_streamer.
module tb_vector_chunk_streamer;
    localparam int EW = 32;
    localparam int NU = 8;
    localparam int MC = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0, wr_sel = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [255:0]  wr_data = '0;
    logic          start = 1'b0;
    logic [31:0]   total = '0;
    logic [255:0]  row_o, vec_o;
    logic          outsider_read_now, I_am_ready = 1'b1, finish = 1'b0;
    logic [31:0]   dot_product_output = '0, result;
    logic          result_valid, busy, err;

    vector_chunk_streamer #(.element_width(EW), .no_of_units(NU), .max_chunks(MC)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .total(total),
        .first_row_plus_additional(row_o), .vector2(vec_o),
        .outsider_read_now(outsider_read_now), .I_am_ready(I_am_ready), .finish(finish),
        .dot_product_output(dot_product_output), .result(result),
        .result_valid(result_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] row;
        logic [255:0] vec;
    } beat_t;

    logic [31:0] m_row [MC][NU];
    logic [31:0] m_vec [MC][NU];
    beat_t       exp_q [$];
    int          beats_seen = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [255:0] pack(input bit sel, input int k);
        logic [255:0] p = '0;
        for (int j = 0; j < NU; j++)
            p[j*EW +: EW] = sel ? m_vec[k][j] : m_row[k][j];
        return p;
    endfunction

    // Element j of beat k is live only inside the buffer and below total.
    function automatic logic [255:0] model_beat(input bit sel, input int k, input int tot);
        logic [255:0] b = '0;
        logic [255:0] p;
        if (k < MC) begin
            p = pack(sel, k);
            for (int j = 0; j < NU; j++)
                if (k * NU + j < tot) b[j*EW +: EW] = p[j*EW +: EW];
        end
        return b;
    endfunction

    task automatic fill_queue(input int tot);
        beat_t b;
        exp_q.delete();
        beats_seen = 0;
        for (int k = 0; k < tot / NU + 2; k++) begin
            b.row = model_beat(0, k, tot);
            b.vec = model_beat(1, k, tot);
            exp_q.push_back(b);
        end
    endtask

    task automatic load(input bit sel, input int addr);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = pack(sel, addr);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic kick(input int tot);
        start = 1'b1; total = tot;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (!reset) begin
            if (outsider_read_now) begin
                chk("read_needs_ready", 256'(I_am_ready), 256'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 256'(outsider_read_now), 256'd0);
                end else begin
                    b = exp_q.pop_front();
                    chk($sformatf("beat%0d_row", beats_seen), row_o, b.row);
                    chk($sformatf("beat%0d_vec", beats_seen), vec_o, b.vec);
                    beats_seen++;
                end
            end else if (busy && beats_seen > 0 && exp_q.size() > 0) begin
                chk("stall_hold_row", row_o, exp_q[0].row);
                chk("stall_hold_vec", vec_o, exp_q[0].vec);
            end else begin
                chk("idle_row_zero", row_o, '0);
                chk("idle_vec_zero", vec_o, '0);
            end
        end
    end

    task automatic run_op(input int tot, input int stall_at, input int stall_len, input int pre_wait,
                          input logic [31:0] dot, input int exp_beats, input bit do_finish);
        int cyc = 0;
        bit stalled = 0;
        fill_queue(tot);
        if (pre_wait > 0) I_am_ready = 1'b0;
        kick(tot);
        for (int i = 0; i < pre_wait; i++) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = {256{1'b1}};
            start = 1'b1; total = 32'd5;
            @(negedge clk);
            chk("busy_wait_ready", 256'(busy), 256'd1);
            chk("no_err_busy_start", 256'(err), 256'd0);
            @(posedge clk); #1;
        end
        wr_en = 1'b0; start = 1'b0; I_am_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (stall_at >= 0 && !stalled && beats_seen == stall_at) begin
                stalled = 1;
                I_am_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_read_low", 256'(outsider_read_now), 256'd0);
                    @(posedge clk); #1;
                end
                I_am_ready = 1'b1;
            end
        end
        chk("stream_timeout", 256'(exp_q.size()), 256'd0);
        chk("beat_count", 256'(beats_seen), 256'(exp_beats));
        @(negedge clk);
        chk("wait_finish_busy", 256'(busy), 256'd1);
        chk("wait_finish_no_valid", 256'(result_valid), 256'd0);
        if (do_finish) begin
            @(posedge clk); #1;
            finish = 1'b1; dot_product_output = dot;
            @(posedge clk); #1;
            finish = 1'b0; dot_product_output = '0;
            @(negedge clk);
            chk("done_valid", 256'(result_valid), 256'd1);
            chk("done_result", 256'(result), 256'(dot));
            chk("done_busy", 256'(busy), 256'd1);
            @(negedge clk);
            chk("after_valid", 256'(result_valid), 256'd0);
            chk("after_busy", 256'(busy), 256'd0);
            chk("result_held", 256'(result), 256'(dot));
        end
    endtask

    initial begin
        int cyc;
        bit saw_valid;
        for (int k = 0; k < MC; k++)
            for (int j = 0; j < NU; j++) begin
                m_row[k][j] = 32'd1;
                m_vec[k][j] = 32'd1;
            end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_err", 256'(err), 256'd0);
        chk("rst_valid", 256'(result_valid), 256'd0);
        chk("rst_read", 256'(outsider_read_now), 256'd0);
        chk("rst_result", 256'(result), 256'd0);
        @(posedge clk); #1;

        for (int k = 0; k < MC; k++) begin
            load(0, k);
            load(1, k);
        end
        finish = 1'b1; dot_product_output = 32'hBAD;
        @(negedge clk);
        @(posedge clk); #1;
        finish = 1'b0;
        @(negedge clk);
        chk("idle_finish_ignored", 256'(result_valid), 256'd0);
        chk("idle_finish_busy", 256'(busy), 256'd0);
        @(posedge clk); #1;

        chk("pin_ones_b0", model_beat(0, 0, 64), {8{32'd1}});
        chk("pin_ones_b8", model_beat(0, 8, 64), '0);
        chk("pin_ones_b9", model_beat(1, 9, 64), '0);
        run_op(64, -1, 0, 0, 32'h0000_0040, 10, 1);
        run_op(64, 4, 3, 0, 32'h0000_1234, 10, 1);

        for (int k = 0; k < MC; k++)
            for (int j = 0; j < NU; j++) begin
                m_row[k][j] = k == 1 ? 32'hDEAD_0000 + j : k * 16 + j + 1;
                m_vec[k][j] = 32'h100 + k * 16 + j;
            end
        for (int k = 0; k < MC; k++) begin
            load(0, k);
            load(1, k);
        end
        for (int j = 0; j < NU; j++) m_row[1][j] = 16 + j + 1;
        chk("pin_t13_b1", model_beat(0, 1, 13),
            {32'd0, 32'd0, 32'd0, 32'd21, 32'd20, 32'd19, 32'd18, 32'd17});
        chk("pin_t13_b2", model_beat(0, 2, 13), '0);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd1; wr_data = pack(0, 1);
        run_op(13, -1, 0, 0, 32'h0000_0077, 3, 1);

        run_op(20, -1, 0, 3, 32'hCAFE_0001, 4, 1);

        @(posedge clk); #1;
        kick(0);
        @(negedge clk);
        chk("err_total0", 256'(err), 256'd1);
        chk("err_total0_busy", 256'(busy), 256'd0);
        @(negedge clk);
        chk("err_total0_pulse", 256'(err), 256'd0);
        @(posedge clk); #1;
        kick(65);
        @(negedge clk);
        chk("err_total65", 256'(err), 256'd1);
        chk("err_total65_busy", 256'(busy), 256'd0);
        @(negedge clk);
        chk("err_total65_pulse", 256'(err), 256'd0);
        @(posedge clk); #1;

        fill_queue(64);
        kick(64);
        cyc = 0;
        while (beats_seen < 5 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_beat5", 256'(beats_seen), 256'd5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_read", 256'(outsider_read_now), 256'd0);
        chk("abort_valid", 256'(result_valid), 256'd0);
        chk("abort_result", 256'(result), 256'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_valid", 256'(result_valid), 256'd0);
        end
        @(posedge clk); #1;
        run_op(64, -1, 0, 0, 32'h0000_0055, 10, 1);

`ifdef STREAMER_TIMEOUT_EN
        @(posedge clk); #1;
        run_op(16, -1, 0, 0, 32'h0, 4, 0);
        cyc = 0;
        saw_valid = 0;
        while (!err && cyc < 1100) begin
            @(posedge clk); #1;
            cyc++;
            if (result_valid) saw_valid = 1;
        end
        chk("timeout_cycles", 256'(cyc), 256'd1024);
        chk("timeout_no_valid", 256'(saw_valid), 256'd0);
        @(negedge clk);
        chk("timeout_done_busy", 256'(busy), 256'd1);
        @(negedge clk);
        chk("timeout_err_pulse", 256'(err), 256'd0);
        chk("timeout_idle", 256'(busy), 256'd0);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vector_chunk_streamer.md
VECTOR_CHUNK_STREAMER -- requirements
Module: vector_chunk_streamer

Interface
REQ-001 SHALL have parameter element_width, default 32, bits per element.
REQ-002 SHALL have parameter no_of_units, default 8, elements per chunk (beat).
REQ-003 SHALL have parameter max_chunks, default 8, buffer depth in chunks per operand.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  buffer write strobe; wr_sel  in  1  0=row buffer, 1=vector buffer; wr_addr  in  clog2(max_chunks)  chunk index; wr_data  in  element_width*no_of_units  chunk data.
REQ-007 start  in  1  begin operation; total  in  32  element count, sampled on accepted start.
REQ-008 first_row_plus_additional  out  element_width*no_of_units  row chunk to consumer; vector2  out  element_width*no_of_units  vector chunk to consumer.
REQ-009 outsider_read_now  out  1  chunk on data outputs valid this cycle.
REQ-010 I_am_ready  in  1  consumer ready; finish  in  1  consumer done; dot_product_output  in  element_width  consumer result.
REQ-011 result  out  element_width; result_valid  out  1; busy  out  1; err  out  1.

Function
REQ-012 FSM states IDLE, WAIT_READY, STREAM, WAIT_FINISH, DONE.
- IDLE->WAIT_READY on start with 1 <= total <= max_chunks*no_of_units.
- WAIT_READY->STREAM when I_am_ready=1.
- STREAM->WAIT_FINISH after the last beat is issued.
- WAIT_FINISH->DONE on finish=1.
- DONE->IDLE after one cycle.
REQ-013 Beat count N = total/no_of_units + 2 (integer division); beats indexed k = 0..N-1.
REQ-014 Beat k data = stored chunk k of each buffer. Element j of beat k is forced to 0 when k*no_of_units+j >= total. Both outputs are all-zero when k >= max_chunks.
REQ-015 outsider_read_now = 1 exactly in STREAM cycles where I_am_ready=1; each such cycle issues one beat, and k increments the next cycle.
REQ-016 I_am_ready=0 during STREAM stalls the stream: outsider_read_now=0, k and data outputs hold.
REQ-017 Data outputs SHALL be registered and present the beat in the same cycle outsider_read_now=1; zero when not streaming.
REQ-018 On finish in WAIT_FINISH, result <= dot_product_output. result_valid=1 for exactly one cycle (the DONE cycle).
REQ-019 finish outside WAIT_FINISH is ignored.
REQ-020 start with total=0 or total > max_chunks*no_of_units: stay IDLE, err=1 for one cycle.
REQ-021 start while busy is ignored.
REQ-022 wr_en writes the buffer only in IDLE; writes in other states are dropped.
REQ-023 busy=1 in every state except IDLE.
REQ-024 start and wr_en in the same IDLE cycle: write completes first, and the stream uses the new data.

Reset
REQ-025 reset SHALL force IDLE, k=0, and outsider_read_now, result_valid, busy, err, data outputs and result all 0 on the next edge.
REQ-026 reset mid-operation SHALL abort immediately with no result_valid; buffer contents are not cleared.

Configuration
REQ-027 With macro STREAMER_TIMEOUT_EN defined:
- a 16-bit counter runs in WAIT_FINISH;
- if it reaches 1024 without finish, go to DONE with result_valid=0 and err=1 for one cycle.
REQ-028 Without STREAMER_TIMEOUT_EN, WAIT_FINISH waits indefinitely and no counter is built.

Verification
REQ-029 Load chunks 0..7 with element value 1 in both buffers, total=64, I_am_ready=1 -> exactly 10 outsider_read_now cycles; beats 8,9 are zero.
REQ-030 total=13, no_of_units=8 -> 3 beats; beat 1 elements 5..7 zero; beat 2 zero.
REQ-031 Drop I_am_ready for 3 cycles at beat 4 -> outsider_read_now low 3 cycles, beat 4 data held, still 10 beats in total.
REQ-032 finish with dot_product_output=0x0000_0040 -> result=0x40, result_valid high exactly 1 cycle, then busy=0.
REQ-033 start with total=0 and with total=65 -> err pulse, busy stays 0; reset at beat 5 -> IDLE next cycle, no result_valid.
REQ-034 With STREAMER_TIMEOUT_EN, withhold finish -> err pulse 1024 cycles after entering WAIT_FINISH, result_valid stays 0.
